// File: rtl/concat_sched.sv
// Concat/requantize sequencer: merges A then B accumulator groups per pixel,
// clamps each 32-bit lane to 8 bits and emits a registered valid/ready stream.
module concat_sched #(
    parameter int RE_CHANNEL_IN_NUM = 8,
    parameter int CNT_W             = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [CNT_W-1:0]                  cfg_groups_a_i,
    input  logic [CNT_W-1:0]                  cfg_groups_b_i,
    input  logic [CNT_W-1:0]                  cfg_pixels_i,
    input  logic                              a_valid_i,
    output logic                              a_ready_o,
    input  logic [32*RE_CHANNEL_IN_NUM-1:0]   a_data_i,
    input  logic                              b_valid_i,
    output logic                              b_ready_o,
    input  logic [32*RE_CHANNEL_IN_NUM-1:0]   b_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [8*RE_CHANNEL_IN_NUM-1:0]    out_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int N = RE_CHANNEL_IN_NUM;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL_A = 2'd1,
        SEL_B = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  grp_q, grp_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [CNT_W-1:0]  ga_q, ga_d;
    logic [CNT_W-1:0]  gb_q, gb_d;
    logic [CNT_W-1:0]  px_q, px_d;
    logic              out_valid_q, out_valid_d;
    logic [8*N-1:0]    out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ld_s;
    logic              a_fire_s;
    logic              b_fire_s;
    logic              pix_end_s;

    // Negative lanes floor at zero; anything above 255 saturates.
    function automatic logic [7:0] clamp_lane(input logic [31:0] x);
        logic [7:0] r;
        if (x[31]) begin
            r = 8'h00;
        end else if (|x[30:8]) begin
            r = 8'hFF;
        end else begin
            r = x[7:0];
        end
        return r;
    endfunction

    function automatic logic [8*N-1:0] clamp_word(input logic [32*N-1:0] w);
        logic [8*N-1:0] r;
        r = {(8*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            r[8*i +: 8] = clamp_lane(w[32*i +: 32]);
        end
        return r;
    endfunction

    assign ld_s      = ~out_valid_q | out_ready_i;
    assign a_ready_o = (state_q == SEL_A) & ld_s;
    assign b_ready_o = (state_q == SEL_B) & ld_s;
    assign a_fire_s  = a_valid_i & a_ready_o;
    assign b_fire_s  = b_valid_i & b_ready_o;

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Next-state logic: group/pixel sequencing and completion.
    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        pix_d     = pix_q;
        ga_d      = ga_q;
        gb_d      = gb_q;
        px_d      = px_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pix_end_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ga_d  = cfg_groups_a_i;
                    gb_d  = cfg_groups_b_i;
                    px_d  = cfg_pixels_i;
                    grp_d = CNT_ZERO;
                    pix_d = CNT_ZERO;
                    if ((cfg_pixels_i == CNT_ZERO) || (cfg_groups_a_i == CNT_ZERO)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEL_A;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEL_A: begin
                if (a_fire_s) begin
                    if (grp_q == ga_q - CNT_ONE) begin
                        grp_d = CNT_ZERO;
                        if (gb_q != CNT_ZERO) begin
                            state_d = SEL_B;
                        end else begin
                            pix_end_s = 1'b1;
                        end
                    end else begin
                        grp_d = grp_q + CNT_ONE;
                    end
                end else begin
                    state_d = SEL_A;
                end
            end
            SEL_B: begin
                if (b_fire_s) begin
                    if (grp_q == gb_q - CNT_ONE) begin
                        grp_d     = CNT_ZERO;
                        pix_end_s = 1'b1;
                    end else begin
                        grp_d = grp_q + CNT_ONE;
                    end
                end else begin
                    state_d = SEL_B;
                end
            end
            DRAIN: begin
                if (ld_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Last group of a pixel either finishes the layer or starts the next pixel at A.
        if (pix_end_s) begin
            if (pix_q == px_q - CNT_ONE) begin
                state_d = DRAIN;
            end else begin
                pix_d   = pix_q + CNT_ONE;
                state_d = SEL_A;
            end
        end else begin
            pix_d = pix_d;
        end
    end

    // Output register load: a transfer refills it, a consume without refill empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (a_fire_s) begin
            out_valid_d = 1'b1;
            out_data_d  = clamp_word(a_data_i);
        end else if (b_fire_s) begin
            out_valid_d = 1'b1;
            out_data_d  = clamp_word(b_data_i);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, counter, config and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grp_q       <= CNT_ZERO;
            pix_q       <= CNT_ZERO;
            ga_q        <= CNT_ZERO;
            gb_q        <= CNT_ZERO;
            px_q        <= CNT_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {(8*N){1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            pix_q       <= pix_d;
            ga_q        <= ga_d;
            gb_q        <= gb_d;
            px_q        <= px_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/concat_sched.md
# concat_sched

Sequencing controller for the concat/requantize stage of the TJPU output path. It merges two 32-bit accumulator streams (branch A, branch B) into one concatenated channel order: per pixel, all A channel groups, then all B channel groups. Each lane is saturated to 8 bits through one registered clamp stage, and the block emits a packed 8-bit-per-lane stream with valid/ready flow control. It sits between the accumulator/bias stage and the output feature-map writer, and owns pixel and group counting plus completion signalling for a concat layer.

## Interface
- RE_CHANNEL_IN_NUM, 8, lanes per word (N)
- CNT_W, 16, width of group and pixel counters and config fields
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches config; ignored while busy
- cfg_groups_a  in  CNT_W  channel groups per pixel from A
- cfg_groups_b  in  CNT_W  channel groups per pixel from B; 0 = A only
- cfg_pixels  in  CNT_W  pixels in layer
- a_valid / a_ready  in / out  1  branch A handshake
- a_data  in  32*N  lane i = bits [32i+31:32i], signed
- b_valid / b_ready  in / out  1  branch B handshake
- b_data  in  32*N  same format as a_data
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  8*N  lane i = bits [8i+7:8i]
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SEL_A, SEL_B, DRAIN.
- IDLE: on start, latch the three cfg fields and clear grp_cnt and pix_cnt.
  - If cfg_pixels==0 or cfg_groups_a==0: no transfers; done pulses next cycle; stay IDLE.
  - Otherwise: go to SEL_A.
- Load condition: ld = (~out_valid | out_ready).
- a_ready = (state==SEL_A) & ld. b_ready = (state==SEL_B) & ld. Both are combinational from state, out_valid and out_ready. a_ready and b_ready are never high together.
- Transfer: valid & ready on the selected source. The word is clamped into out_data and out_valid is set.
- Clamp, per lane x[31:0]:
  - x[31]=1 → 0x00.
  - Else x[30:8]≠0 → 0xFF.
  - Else x[7:0].
- SEL_A transfer: grp_cnt++.
  - At grp_cnt==groups_a-1: clear grp_cnt. Go to SEL_B if groups_b≠0; otherwise end the pixel.
- SEL_B transfer: grp_cnt++.
  - At grp_cnt==groups_b-1: clear grp_cnt and end the pixel.
- Pixel end: if pix_cnt==pixels-1, go to DRAIN. Else pix_cnt++ and go to SEL_A.
- DRAIN: no source accepted.
  - Once the output register is empty or being emptied (out_valid==0, or out_valid&out_ready), the next cycle has state=IDLE, busy=0, done=1.
- Output register: when out_valid & out_ready and no new load, out_valid clears. out_data holds its value while out_valid & ~out_ready.
- The unselected source is never read; its valid is ignored.

## Timing
- Reset values: a_ready=0, b_ready=0, out_valid=0, out_data=0, busy=0, done=0, state=IDLE, counters=0. Reset mid-layer aborts: no done pulse, in-flight output dropped.
- start at cycle t → state SEL_A and busy=1 at t+1. The first a_ready can assert at t+1.
- Latency: input transfer at cycle t → out_valid and out_data valid at t+1.
- Throughput: one word per cycle when out_ready is held high.
- Backpressure: out_valid & ~out_ready → a_ready=b_ready=0. Data is held stable.
- A→B and B→A switches cost no bubble. The last A transfer at t allows the first B transfer at t+1.
- done and busy=0 occur in the same cycle. A start in that cycle is accepted.
- start while busy has no effect. Config changes while busy have no effect.

## Test plan
- Clamp lanes: one pixel, groups_a=1, groups_b=0, lane values {0x0000_0000, 0x0000_007F, 0x0000_00FF, 0x0000_0100, 0x7FFF_FFFF, 0x8000_0000, 0xFFFF_FFFF, 0x0000_0080} → out lanes {00,7F,FF,FF,FF,00,00,80}; done 1 cycle after output accepted.
- Order: groups_a=2, groups_b=3, pixels=2, sources always valid, out_ready=1 → source sequence A,A,B,B,B,A,A,B,B,B; 10 outputs on consecutive cycles; single done pulse.
- Backpressure: same config as Order; toggle out_ready randomly → no word lost, duplicated or reordered; out_data stable while stalled.
- Bubbles: a_valid low for 3 cycles in SEL_A while b_valid is high → b_data not consumed; state holds; resumes correctly.
- Degenerate config: cfg_pixels=0 → done at start+1, no ready asserted. groups_b=0 → b_ready never asserts.
- Reset and restart: assert rst mid-pixel 2 → all outputs 0 next cycle, no done. Then start a new layer → correct sequence from pixel 0, group 0.
